ppm_slot_modulator: RTL and testbench

- Downstream neighbour of the bitstream generator. Consumes its serial `bitstream`/`bitstream_valid` output (one bit per BIT_CLKS clocks).
- Packs bit pairs into 4-PPM symbols and drives the optical slot output `ppm_out`.
- Also owns the `ppm_ready` start handshake back to the generator.

---
 rtl/ppm_slot_modulator.sv | 154 +++++++++++++++
 tb/tb_ppm_slot_modulator.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ppm_slot_modulator.sv
// ppm_slot_modulator: packs serial bit pairs into 4-PPM symbols and drives the optical slot output
// Ports: clk; reset_n async active-low; enable arms one frame; bitstream/bitstream_valid from the
// generator; ppm_ready start request to the generator; ppm_out slot pulse; ppm_valid high during
// symbol frames; symbol_count frames emitted this run (wraps); done flags a completed frame.
module ppm_slot_modulator #(
  parameter int CLK1X_FREQ = 100,
  parameter int BIT_CLKS   = 500000 / CLK1X_FREQ,
  parameter int SLOT_CLKS  = BIT_CLKS / 2,
  parameter int PULSE_CLKS = BIT_CLKS / 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        bitstream,
  input  logic        bitstream_valid,
  output logic        ppm_ready,
  output logic        ppm_out,
  output logic        ppm_valid,
  output logic [15:0] symbol_count,
  output logic        done
);
  localparam int BW = $clog2(BIT_CLKS);
  localparam int SW = $clog2(4 * SLOT_CLKS);
  localparam logic [BW-1:0] BIT_MID  = BW'(BIT_CLKS / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CLKS - 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(4 * SLOT_CLKS - 1);
  typedef enum logic [2:0] {IDLE, ARM, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] sym_cnt_q, sym_cnt_d;
  logic [15:0] count_q, count_d;
  logic [1:0] emit_q, emit_d, q_sym_q, q_sym_d, load_sym;
  logic odd_q, odd_d, half_q, half_d, msb_q, msb_d, lsb_q, lsb_d;
  logic q_v_q, q_v_d, busy_q, busy_d, out_q, out_d, last, load;
  int lo;
  always_comb begin
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    sym_cnt_d = sym_cnt_q;
    count_d = count_q;
    emit_d = emit_q;
    q_sym_d = q_sym_q;
    q_v_d = q_v_q;
    odd_d = odd_q;
    half_d = half_q;
    msb_d = msb_q;
    lsb_d = lsb_q;
    busy_d = busy_q;
    load = 1'b0;
    load_sym = 2'd0;
    last = busy_q && sym_cnt_q == SYM_LAST;
    if (busy_q) begin
      sym_cnt_d = last ? '0 : sym_cnt_q + 1'b1;
      busy_d = !last;
      count_d = last ? count_q + 16'd1 : count_q;
    end
    case (state_q)
      IDLE: if (enable) begin
        state_d = ARM;
        count_d = '0;
      end
      // The cycle that first sees bitstream_valid is count 0 of bit 0, so the counter resumes at 1.
      ARM: if (!enable) state_d = IDLE;
        else if (bitstream_valid) begin
          state_d = RUN;
          bit_cnt_d = BW'(1);
          odd_d = 1'b0;
          half_d = 1'b0;
        end
      // half_q marks a completed even bit (MSB) still waiting for its LSB.
      RUN: if (!enable) state_d = IDLE;
        else if (!bitstream_valid) begin
          state_d = FLUSH;
          half_d = 1'b0;
          load = half_q && (!busy_q || last);
          load_sym = {msb_q, 1'b0};
          q_v_d = half_q && busy_q && !last;
          q_sym_d = {msb_q, 1'b0};
        end else begin
          bit_cnt_d = bit_cnt_q == BIT_LAST ? '0 : bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_MID) begin
            msb_d = odd_q ? msb_q : bitstream;
            lsb_d = odd_q ? bitstream : lsb_q;
          end
          if (bit_cnt_q == BIT_LAST) begin
            odd_d = !odd_q;
            half_d = !odd_q;
            load = odd_q;
            load_sym = {msb_q, lsb_q};
          end
        end
      FLUSH: if (!enable) state_d = IDLE;
        else if (!busy_q || last) begin
          state_d = q_v_q ? FLUSH : DONE;
          load = q_v_q;
          load_sym = q_sym_q;
          q_v_d = 1'b0;
        end
      DONE: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      busy_d = 1'b1;
      sym_cnt_d = '0;
      emit_d = load_sym;
    end
    if (state_d == IDLE) begin
      busy_d = 1'b0;
      sym_cnt_d = '0;
      bit_cnt_d = '0;
      q_v_d = 1'b0;
      half_d = 1'b0;
      odd_d = 1'b0;
    end
    lo = int'(emit_d) * SLOT_CLKS;
    out_d = busy_d && int'(sym_cnt_d) >= lo && int'(sym_cnt_d) < lo + PULSE_CLKS;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      sym_cnt_q <= '0;
      count_q <= '0;
      emit_q <= '0;
      q_sym_q <= '0;
      q_v_q <= 1'b0;
      odd_q <= 1'b0;
      half_q <= 1'b0;
      msb_q <= 1'b0;
      lsb_q <= 1'b0;
      busy_q <= 1'b0;
      out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sym_cnt_q <= sym_cnt_d;
      count_q <= count_d;
      emit_q <= emit_d;
      q_sym_q <= q_sym_d;
      q_v_q <= q_v_d;
      odd_q <= odd_d;
      half_q <= half_d;
      msb_q <= msb_d;
      lsb_q <= lsb_d;
      busy_q <= busy_d;
      out_q <= out_d;
    end
  end
  assign ppm_ready = state_q == ARM;
  assign done = state_q == DONE;
  assign ppm_valid = busy_q;
  assign ppm_out = out_q;
  assign symbol_count = count_q;
endmodule

// File: tb/tb_ppm_slot_modulator.sv
// tb_ppm_slot_modulator: directed bench for ppm_slot_modulator with BIT_CLKS=8, SLOT_CLKS=4, PULSE_CLKS=2
module tb_ppm_slot_modulator;
  logic clk, reset_n, enable, bitstream, bitstream_valid;
  logic ppm_ready, ppm_out, ppm_valid, done;
  logic [15:0] symbol_count;
  int n_checks = 0;
  int n_fail = 0;
  ppm_slot_modulator #(.BIT_CLKS(8), .PULSE_CLKS(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .bitstream(bitstream),
    .bitstream_valid(bitstream_valid),
    .ppm_ready(ppm_ready),
    .ppm_out(ppm_out),
    .ppm_valid(ppm_valid),
    .symbol_count(symbol_count),
    .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Starts in ARM. t counts negedges from the one that raises bitstream_valid; bit k is held for
  // 8 clocks from t=8k, symbol j occupies t in [16+16j, 32+16j), 2-bit field j of syms is symbol j.
  task automatic play(input logic [31:0] bits, input int nbits, input logic [31:0] syms, input int nsym);
    int tend, j, sc, s, ecnt;
    logic ev, eo;
    tend = 16 + 16 * nsym;
    for (int t = 0; t <= tend + 1; t++) begin
      @(negedge clk);
      ev = t >= 16 && t < tend;
      j = ev ? (t - 16) / 16 : 0;
      sc = ev ? (t - 16) % 16 : 0;
      s = int'(syms[2 * j +: 2]);
      eo = ev && sc >= 4 * s && sc < 4 * s + 2;
      ecnt = t < 32 ? 0 : ((t - 16) / 16 > nsym ? nsym : (t - 16) / 16);
      chk($sformatf("ready t=%0d", t), 32'(ppm_ready), 32'(t == 0));
      chk($sformatf("valid t=%0d", t), 32'(ppm_valid), 32'(ev));
      chk($sformatf("out t=%0d", t), 32'(ppm_out), 32'(eo));
      chk($sformatf("count t=%0d", t), 32'(symbol_count), 32'(ecnt));
      chk($sformatf("done t=%0d", t), 32'(done), 32'(t >= tend));
      bitstream_valid = t < 8 * nbits;
      bitstream = t < 8 * nbits ? bits[t / 8] : 1'b0;
    end
  endtask
  task automatic rearm();
    enable = 1'b0;
    @(negedge clk);
    chk("done_clear", 32'(done), 0);
    chk("ready_idle", 32'(ppm_ready), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("ready_arm", 32'(ppm_ready), 1);
    chk("count_clear", 32'(symbol_count), 0);
  endtask
  task automatic zeros16();
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      bitstream_valid = 1'b1;
      bitstream = 1'b0;
    end
    @(negedge clk);
  endtask
  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    bitstream = 1'b0;
    bitstream_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ppm_ready), 0);
    chk("rst_out", 32'(ppm_out), 0);
    chk("rst_valid", 32'(ppm_valid), 0);
    chk("rst_count", 32'(symbol_count), 0);
    chk("rst_done", 32'(done), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(ppm_ready), 0);
    enable = 1'b1;
    play(32'h39, 8, 32'h36, 4);
    rearm();
    play(32'h7, 3, 32'hB, 2);
    rearm();
    play(32'h55555, 20, 32'hAAAAA, 10);
    rearm();
    zeros16();
    chk("abort_pre_out", 32'(ppm_out), 1);
    chk("abort_pre_valid", 32'(ppm_valid), 1);
    enable = 1'b0;
    bitstream_valid = 1'b0;
    @(negedge clk);
    chk("abort_out", 32'(ppm_out), 0);
    chk("abort_valid", 32'(ppm_valid), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ready", 32'(ppm_ready), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("abort_rearm", 32'(ppm_ready), 1);
    zeros16();
    chk("arst_pre_out", 32'(ppm_out), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", 32'(ppm_out), 0);
    chk("arst_valid", 32'(ppm_valid), 0);
    chk("arst_ready", 32'(ppm_ready), 0);
    @(negedge clk);
    enable = 1'b0;
    bitstream_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out", 32'(ppm_out), 0);
    chk("post_rst_valid", 32'(ppm_valid), 0);
    chk("post_rst_done", 32'(done), 0);
    chk("post_rst_count", 32'(symbol_count), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("post_rst_arm", 32'(ppm_ready), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
